score_result_buffer: RTL and testbench

//  Parametrised, double-buffered store for classifier output scores. Captures one score per

---
 rtl/score_buf_pkg.sv | 45 ++++
 rtl/score_result_buffer_if.sv | 34 +++
 rtl/score_bank_ram.sv | 30 +++
 rtl/score_result_buffer.sv | 176 +++++++++++++++++
 tb/tb_score_result_buffer.sv | 381 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/score_buf_pkg.sv
// Shared types and address-map helpers for the double-buffered score store.
// Contents: default parameter values, FSM state enum, read-select enum, and
// constant functions deriving byte count, word-address width and metadata offsets.
package score_buf_pkg;

    localparam int unsigned DEF_NUM_CLASSES = 10;
    localparam int unsigned DEF_SCORE_W     = 32;
    localparam int unsigned DEF_ADDR_W      = 8;
    localparam int unsigned DEF_BYTES       = DEF_SCORE_W / 8;

    typedef enum logic {
        S_FILL,
        S_COMMIT
    } state_t;

    typedef enum logic [1:0] {
        RD_SCORE,
        RD_PRED,
        RD_SEQ,
        RD_ZERO
    } rd_sel_t;

    // Bytes per score word.
    function automatic int unsigned bytes_of(input int unsigned score_w);
        return score_w / 8;
    endfunction

    // Word address width covering both banks.
    function automatic int unsigned word_addr_w(input int unsigned num_classes);
        return $clog2(2 * num_classes);
    endfunction

    // Byte address of pred_class in the read map.
    function automatic int unsigned pred_ofs(input int unsigned num_classes,
                                             input int unsigned score_w);
        return num_classes * bytes_of(score_w);
    endfunction

    // Byte address of frame_seq in the read map.
    function automatic int unsigned seq_ofs(input int unsigned num_classes,
                                            input int unsigned score_w);
        return pred_ofs(num_classes, score_w) + 1;
    endfunction

endpackage

// File: rtl/score_result_buffer_if.sv
// Score-write, byte-readout and result-status bundle of score_result_buffer.
// master: inference datapath + UART host side; slave: the buffer.
//   wr_valid/wr_ready/wr_score/wr_last/wr_abort : score beat stream
//   rd_addr/rd_data                              : byte readout, 1-cycle latency
//   result_ack/result_valid/pred_class/frame_err : result status
interface score_result_buffer_if
    import score_buf_pkg::*;
#(
    parameter int unsigned SCORE_W = DEF_SCORE_W,
    parameter int unsigned ADDR_W  = DEF_ADDR_W
);
    logic               wr_valid;
    logic               wr_ready;
    logic [SCORE_W-1:0] wr_score;
    logic               wr_last;
    logic               wr_abort;
    logic [ADDR_W-1:0]  rd_addr;
    logic [7:0]         rd_data;
    logic               result_ack;
    logic               result_valid;
    logic [7:0]         pred_class;
    logic               frame_err;

    modport master (
        output wr_valid, wr_score, wr_last, wr_abort, rd_addr, result_ack,
        input  wr_ready, rd_data, result_valid, pred_class, frame_err
    );

    modport slave (
        input  wr_valid, wr_score, wr_last, wr_abort, rd_addr, result_ack,
        output wr_ready, rd_data, result_valid, pred_class, frame_err
    );

endinterface

// File: rtl/score_bank_ram.sv
// Simple dual-port score RAM holding both banks (2*NUM_CLASSES words).
// Ports: clk; we_i/waddr_i/wdata_i synchronous write; raddr_i -> rdata_o
// synchronous read (data valid the cycle after the address).
module score_bank_ram #(
    parameter int unsigned DEPTH = 20,
    parameter int unsigned WIDTH = 32,
    parameter int unsigned AW    = 5
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    (* ram_style = "block" *) logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] rdata_q;

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        rdata_q <= mem_q[raddr_i];
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/score_result_buffer.sv
// Double-buffered classifier score store with on-the-fly argmax.
// Scores stream into the fill bank in class order; a well-formed frame
// commits in one cycle (bank swap + metadata update) so the readout side
// only ever sees complete results.
// Ports: clk, rst (sync, active-high), bus (score_result_buffer_if.slave).
module score_result_buffer
    import score_buf_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = DEF_NUM_CLASSES,
    parameter int unsigned SCORE_W     = DEF_SCORE_W,
    parameter int unsigned ADDR_W      = DEF_ADDR_W
) (
    input logic                  clk,
    input logic                  rst,
    score_result_buffer_if.slave bus
);

    localparam int unsigned SCORE_BYTES = bytes_of(SCORE_W);
    localparam int unsigned LANE_W      = (SCORE_BYTES > 1) ? $clog2(SCORE_BYTES) : 1;
    localparam int unsigned IDX_W       = $clog2(NUM_CLASSES);
    localparam int unsigned WA_W        = word_addr_w(NUM_CLASSES);
    localparam int unsigned PRED_A      = pred_ofs(NUM_CLASSES, SCORE_W);
    localparam int unsigned SEQ_A       = seq_ofs(NUM_CLASSES, SCORE_W);
    localparam int unsigned LAST_IDX    = NUM_CLASSES - 1;

    state_t                    state_q, state_d;
    logic [IDX_W-1:0]          idx_q, idx_d;
    logic signed [SCORE_W-1:0] max_q, max_d;
    logic [IDX_W-1:0]          arg_q, arg_d;
    logic                      bank_sel_q, bank_sel_d;
    logic [7:0]                pred_q, pred_d;
    logic [7:0]                seq_q, seq_d;
    logic                      rv_q, rv_d;
    logic                      err_q, err_d;
    logic                      ready_q, ready_d;

    rd_sel_t                   rd_sel_q, rd_sel_d;
    logic [LANE_W-1:0]         lane_q, lane_d;
    logic [7:0]                meta_q, meta_d;
    logic [WA_W-1:0]           word_c;
    logic [WA_W-1:0]           raddr_c;
    logic [WA_W-1:0]           waddr_c;
    logic [SCORE_W-1:0]        ram_rdata;

    logic fire_c;
    logic at_last_c;
    logic beat_gt_c;

    assign fire_c    = bus.wr_valid && ready_q && !bus.wr_abort;
    assign at_last_c = (idx_q == IDX_W'(LAST_IDX));
    assign beat_gt_c = ($signed(bus.wr_score) > max_q);

    // bank_sel_q names the committed bank; the other one is filling.
    assign waddr_c = bank_sel_q ? WA_W'(idx_q) : WA_W'(NUM_CLASSES) + WA_W'(idx_q);

    // Fill/commit FSM, argmax tracking and result metadata.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        max_d      = max_q;
        arg_d      = arg_q;
        bank_sel_d = bank_sel_q;
        pred_d     = pred_q;
        seq_d      = seq_q;
        rv_d       = rv_q && !bus.result_ack;
        err_d      = 1'b0;
        unique case (state_q)
            S_FILL: begin
                if (bus.wr_abort) begin
                    idx_d = '0;
                    max_d = '0;
                    arg_d = '0;
                end else if (fire_c) begin
                    // Strict compare keeps the lowest index on ties.
                    if ((idx_q == '0) || beat_gt_c) begin
                        max_d = $signed(bus.wr_score);
                        arg_d = idx_q;
                    end
                    if (bus.wr_last && at_last_c) begin
                        state_d = S_COMMIT;
                    end else if (bus.wr_last || at_last_c) begin
                        err_d = 1'b1;
                        idx_d = '0;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
            S_COMMIT: begin
                // A new result wins over an ack in the same cycle.
                bank_sel_d = !bank_sel_q;
                pred_d     = 8'(arg_q);
                seq_d      = seq_q + 8'd1;
                rv_d       = 1'b1;
                idx_d      = '0;
                state_d    = S_FILL;
            end
            default: state_d = S_FILL;
        endcase
        ready_d = (state_d == S_FILL);
    end

    // Read decode; metadata is captured with the address so a read in the
    // commit cycle returns a coherent pre-swap view.
    always_comb begin
        rd_sel_d = RD_ZERO;
        word_c   = '0;
        lane_d   = '0;
        meta_d   = 8'h00;
        if (bus.rd_addr < ADDR_W'(PRED_A)) begin
            rd_sel_d = RD_SCORE;
            word_c   = WA_W'(bus.rd_addr / ADDR_W'(SCORE_BYTES));
            lane_d   = LANE_W'(bus.rd_addr % ADDR_W'(SCORE_BYTES));
        end else if (bus.rd_addr == ADDR_W'(PRED_A)) begin
            rd_sel_d = RD_PRED;
            meta_d   = pred_q;
        end else if (bus.rd_addr == ADDR_W'(SEQ_A)) begin
            rd_sel_d = RD_SEQ;
            meta_d   = seq_q;
        end
        raddr_c = bank_sel_q ? WA_W'(NUM_CLASSES) + word_c : word_c;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_FILL;
            idx_q      <= '0;
            max_q      <= '0;
            arg_q      <= '0;
            bank_sel_q <= 1'b0;
            pred_q     <= 8'h00;
            seq_q      <= 8'h00;
            rv_q       <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            rd_sel_q   <= RD_ZERO;
            lane_q     <= '0;
            meta_q     <= 8'h00;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            max_q      <= max_d;
            arg_q      <= arg_d;
            bank_sel_q <= bank_sel_d;
            pred_q     <= pred_d;
            seq_q      <= seq_d;
            rv_q       <= rv_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            rd_sel_q   <= rd_sel_d;
            lane_q     <= lane_d;
            meta_q     <= meta_d;
        end
    end

    score_bank_ram #(
        .DEPTH (2 * NUM_CLASSES),
        .WIDTH (SCORE_W),
        .AW    (WA_W)
    ) u_ram (
        .clk     (clk),
        .we_i    (fire_c),
        .waddr_i (waddr_c),
        .wdata_i (bus.wr_score),
        .raddr_i (raddr_c),
        .rdata_o (ram_rdata)
    );

    // Byte lane select over registered RAM data / captured metadata.
    assign bus.rd_data      = (rd_sel_q == RD_SCORE) ? 8'(ram_rdata >> {lane_q, 3'b000}) : meta_q;
    assign bus.wr_ready     = ready_q;
    assign bus.result_valid = rv_q;
    assign bus.pred_class   = pred_q;
    assign bus.frame_err    = err_q;

endmodule

// File: tb/tb_score_result_buffer.sv
// Self-checking bench for score_result_buffer: table vectors, directed
// multi-cycle sequences and random traffic against a frame-level model.
module tb_score_result_buffer;

    localparam int unsigned NC = 10;
    localparam int unsigned SW = 32;
    localparam int unsigned AW = 8;
    localparam int unsigned NB = SW / 8;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    score_result_buffer_if #(.SCORE_W(SW), .ADDR_W(AW)) bus ();
    score_result_buffer_if #(.SCORE_W(16), .ADDR_W(AW)) bus2 ();

    score_result_buffer #(.NUM_CLASSES(NC), .SCORE_W(SW), .ADDR_W(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    score_result_buffer #(.NUM_CLASSES(4), .SCORE_W(16), .ADDR_W(AW)) dut2 (
        .clk (clk),
        .rst (rst),
        .bus (bus2)
    );

    int n_assert = 0;
    int n_fail   = 0;

    // Frame-level reference state
    logic signed [SW-1:0] m_cur[$];
    logic signed [SW-1:0] m_stage[NC];
    logic signed [SW-1:0] m_com[NC];
    bit                   m_staged = 0;
    bit                   m_known  = 0;
    bit                   m_ready  = 0;
    bit                   m_rv     = 0;
    logic [7:0]           m_pred   = 8'h00;
    logic [7:0]           m_seq    = 8'h00;

    typedef struct {
        logic signed [SW-1:0] s[NC];
        logic [7:0]           exp_pred;
    } frame_vec_t;

    typedef struct {
        logic [AW-1:0] addr;
        logic [7:0]    exp;
    } rd_vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] ref_argmax(input logic signed [SW-1:0] s[NC]);
        int best;
        best = 0;
        for (int i = 1; i < NC; i++) begin
            if (s[i] > s[best]) best = i;
        end
        return 8'(best);
    endfunction

    function automatic logic [SW-1:0] rand_score();
        if ($urandom_range(0, 1) == 1) return SW'($urandom);
        return SW'(int'($urandom_range(0, 6)) - 3);
    endfunction

    task automatic rand_frame(output logic signed [SW-1:0] s[NC]);
        for (int i = 0; i < NC; i++) s[i] = rand_score();
    endtask

    task automatic idle();
        bus.wr_valid   = 1'b0;
        bus.wr_last    = 1'b0;
        bus.wr_abort   = 1'b0;
        bus.result_ack = 1'b0;
    endtask

    // One clock: predict from the current inputs, advance, compare.
    task automatic step();
        logic [7:0] e_rd;
        bit         rd_chk;
        bit         e_err;
        int         a;
        a      = int'(bus.rd_addr);
        rd_chk = 1;
        e_rd   = 8'h00;
        e_err  = 0;
        if (a < NC * NB) begin
            rd_chk = m_known;
            e_rd   = 8'(m_com[a / NB] >> (8 * (a % NB)));
        end else if (a == NC * NB) begin
            e_rd = m_pred;
        end else if (a == NC * NB + 1) begin
            e_rd = m_seq;
        end
        if (rst) begin
            m_cur.delete();
            m_staged = 0;
            m_known  = 0;
            m_ready  = 0;
            m_rv     = 0;
            m_pred   = 8'h00;
            m_seq    = 8'h00;
            e_rd     = 8'h00;
            rd_chk   = 1;
        end else begin
            if (m_staged) begin
                m_com    = m_stage;
                m_pred   = ref_argmax(m_stage);
                m_seq    = m_seq + 8'd1;
                m_rv     = 1;
                m_staged = 0;
                m_known  = 1;
            end else if (bus.result_ack) begin
                m_rv = 0;
            end
            if (m_ready && bus.wr_abort) begin
                m_cur.delete();
            end else if (m_ready && bus.wr_valid) begin
                if (bus.wr_last && m_cur.size() == NC - 1) begin
                    for (int i = 0; i < NC - 1; i++) m_stage[i] = m_cur[i];
                    m_stage[NC-1] = bus.wr_score;
                    m_staged = 1;
                    m_cur.delete();
                end else if (bus.wr_last || m_cur.size() == NC - 1) begin
                    e_err = 1;
                    m_cur.delete();
                end else begin
                    m_cur.push_back(bus.wr_score);
                end
            end
            m_ready = !m_staged;
        end
        @(posedge clk);
        #1;
        chk("wr_ready", bus.wr_ready, m_ready);
        chk("result_valid", bus.result_valid, m_rv);
        chk("pred_class", bus.pred_class, m_pred);
        chk("frame_err", bus.frame_err, e_err);
        if (rd_chk) chk("rd_data", bus.rd_data, e_rd);
    endtask

    task automatic send_frame(input logic signed [SW-1:0] s[NC]);
        int guard;
        for (int i = 0; i < NC; i++) begin
            idle();
            guard = 0;
            while (!m_ready && guard < 4) begin
                step();
                guard++;
            end
            if (!m_ready) begin
                n_assert++;
                n_fail++;
                $display("FAIL ready_timeout: got 0 expected 1 at %0t", $time);
            end
            bus.wr_valid = 1'b1;
            bus.wr_score = s[i];
            bus.wr_last  = (i == NC - 1);
            bus.rd_addr  = AW'($urandom_range(0, NC * NB + 2));
            step();
        end
        idle();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_vec_t           fv[3];
        rd_vec_t              rt[9];
        rd_vec_t              rt2[6];
        logic signed [SW-1:0] fr[NC];
        logic signed [15:0]   s2[4];
        logic [7:0]           old_pred;
        logic [7:0]           seq0;

        fv[0].s = '{-5, 3, 7, 7, -100, 0, 1, 2, 6, 4};
        fv[0].exp_pred = 8'd2;
        fv[1].s = '{default: 32'h8000_0000};
        fv[1].exp_pred = 8'd0;
        fv[2].s = '{-9, -8, -7, -6, -5, -4, -3, -2, -1, -1};
        fv[2].exp_pred = 8'd8;

        rt = '{'{8'd8, 8'h07}, '{8'd9, 8'h00}, '{8'd10, 8'h00}, '{8'd11, 8'h00},
               '{8'd0, 8'hFB}, '{8'd16, 8'h9C}, '{8'd40, 8'h02}, '{8'd41, 8'h01},
               '{8'd42, 8'h00}};
        s2  = '{-5, 3, 7, 7};
        rt2 = '{'{8'd4, 8'h07}, '{8'd5, 8'h00}, '{8'd0, 8'hFB}, '{8'd8, 8'h02},
                '{8'd9, 8'h01}, '{8'd10, 8'h00}};

        rst = 1'b1;
        idle();
        bus.wr_score    = '0;
        bus.rd_addr     = '0;
        bus2.wr_valid   = 1'b0;
        bus2.wr_score   = '0;
        bus2.wr_last    = 1'b0;
        bus2.wr_abort   = 1'b0;
        bus2.rd_addr    = '0;
        bus2.result_ack = 1'b0;
        step();
        step();
        chk("rst_ready", bus.wr_ready, 1'b0);
        chk("rst_valid", bus.result_valid, 1'b0);
        chk("rst_pred", bus.pred_class, 8'h00);
        chk("rst_rd", bus.rd_data, 8'h00);
        rst = 1'b0;
        step();
        chk("ready_after_rst", bus.wr_ready, 1'b1);

        // Vector frames with table-driven expectations
        for (int v = 0; v < 3; v++) begin
            send_frame(fv[v].s);
            step();
            chk("vec_pred", bus.pred_class, fv[v].exp_pred);
            chk("vec_valid", bus.result_valid, 1'b1);
            if (v == 0) begin
                for (int r = 0; r < 9; r++) begin
                    bus.rd_addr = rt[r].addr;
                    step();
                    chk("vec_rd", bus.rd_data, rt[r].exp);
                end
            end
            if (v == 1) begin
                bus.rd_addr = 8'd3;
                step();
                chk("min_byte3", bus.rd_data, 8'h80);
                for (int a = 42; a < 256; a++) begin
                    bus.rd_addr = AW'(a);
                    step();
                    chk("rd_above_map", bus.rd_data, 8'h00);
                end
            end
        end

        // Early wr_last: one-cycle error pulse, committed result untouched
        for (int i = 0; i < 6; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_score = rand_score();
            bus.wr_last  = (i == 5);
            step();
        end
        chk("err_early_last", bus.frame_err, 1'b1);
        idle();
        bus.rd_addr = AW'(NC * NB);
        step();
        chk("err_single_cycle", bus.frame_err, 1'b0);
        chk("err_keep_pred", bus.rd_data, fv[2].exp_pred);

        // Missing wr_last on the final beat
        for (int i = 0; i < NC; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_score = rand_score();
            bus.wr_last  = 1'b0;
            step();
        end
        chk("err_missing_last", bus.frame_err, 1'b1);
        idle();
        rand_frame(fr);
        send_frame(fr);
        step();
        chk("recover_valid", bus.result_valid, 1'b1);
        bus.rd_addr = AW'(NC * NB + 1);
        step();
        chk("recover_seq", bus.rd_data, 8'd4);

        // Ack, then readout of bank A while bank B fills; ack in the commit cycle
        bus.result_ack = 1'b1;
        step();
        bus.result_ack = 1'b0;
        chk("ack_clears", bus.result_valid, 1'b0);
        rand_frame(fr);
        send_frame(fr);
        old_pred       = m_pred;
        bus.result_ack = 1'b1;
        bus.rd_addr    = AW'(NC * NB);
        step();
        chk("ack_in_commit", bus.result_valid, 1'b1);
        chk("commit_cycle_old_pred", bus.rd_data, old_pred);
        bus.result_ack = 1'b0;
        step();
        chk("post_commit_new_pred", bus.rd_data, ref_argmax(fr));

        // Abort after 4 beats (beat in the abort cycle is dropped)
        seq0 = m_seq;
        for (int i = 0; i < 4; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_score = 32'h7FFF_FFFF;
            bus.wr_last  = 1'b0;
            step();
        end
        bus.wr_abort = 1'b1;
        step();
        chk("abort_no_err", bus.frame_err, 1'b0);
        idle();
        send_frame(fv[0].s);
        step();
        chk("abort_pred", bus.pred_class, 8'd2);
        bus.rd_addr = AW'(NC * NB + 1);
        step();
        chk("abort_seq", bus.rd_data, seq0 + 8'd1);

        // Random traffic
        for (int c = 0; c < 1500; c++) begin
            bus.wr_valid = ($urandom_range(0, 3) != 0);
            bus.wr_score = rand_score();
            if (m_cur.size() == NC - 1) bus.wr_last = ($urandom_range(0, 9) != 0);
            else                        bus.wr_last = ($urandom_range(0, 24) == 0);
            bus.wr_abort   = ($urandom_range(0, 39) == 0);
            bus.result_ack = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 3) == 0) bus.rd_addr = AW'($urandom_range(0, 255));
            else                           bus.rd_addr = AW'($urandom_range(0, NC * NB + 3));
            step();
        end
        idle();
        step();
        step();

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) begin
            bus.wr_valid = 1'b1;
            bus.wr_score = rand_score();
            step();
        end
        idle();
        rst         = 1'b1;
        bus.rd_addr = AW'(NC * NB);
        step();
        chk("rst_mid_valid", bus.result_valid, 1'b0);
        chk("rst_mid_pred", bus.pred_class, 8'h00);
        chk("rst_mid_rd", bus.rd_data, 8'h00);
        rst = 1'b0;
        step();

        // 256 frames wrap frame_seq back to zero
        for (int f = 0; f < 256; f++) begin
            rand_frame(fr);
            send_frame(fr);
        end
        step();
        bus.rd_addr = AW'(NC * NB + 1);
        step();
        chk("seq_wrap", bus.rd_data, 8'h00);
        chk("seq_wrap_valid", bus.result_valid, 1'b1);

        // Narrow configuration: 4 classes x 16-bit scores
        chk("d2_ready", bus2.wr_ready, 1'b1);
        for (int i = 0; i < 4; i++) begin
            bus2.wr_valid = 1'b1;
            bus2.wr_score = s2[i];
            bus2.wr_last  = (i == 3);
            step();
        end
        bus2.wr_valid = 1'b0;
        bus2.wr_last  = 1'b0;
        step();
        chk("d2_pred", bus2.pred_class, 8'd2);
        chk("d2_valid", bus2.result_valid, 1'b1);
        for (int r = 0; r < 6; r++) begin
            bus2.rd_addr = rt2[r].addr;
            step();
            chk("d2_rd", bus2.rd_data, rt2[r].exp);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
